// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified-memory arbiter.
// Covers the FSM state encoding, the owner tag and the streak counter width.
package mem_arb_pkg;

    localparam int DEF_AW           = 32;
    localparam int DEF_DW           = 32;
    localparam int DEF_MAX_D_STREAK = 4;
    localparam int STREAK_W         = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU fetch/load-store ports, the arbiter and the unified memory.
// slave is the arbiter's view; master is the view of the surrounding core and memory.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);

    logic              if_req;
    logic [AW-1:0]     if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DW-1:0]     if_rdata;

    logic              d_req;
    logic              d_we;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_wdata;
    logic [DW/8-1:0]   d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DW-1:0]     d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_be;
    logic              mem_ack;
    logic [DW-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and data requests.
// Data normally wins; a saturating streak counter lets a waiting fetch through.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic d_req,
    input  logic arb_en,
    output logic grant_i,
    output logic grant_d
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    logic [STREAK_W-1:0] streak_reg, streak_next;

    assign grant_d = arb_en && d_req && (!if_req || (streak_reg < STREAK_MAX));
    assign grant_i = arb_en && if_req && !grant_d;

    // Streak only counts data grants that actually made a fetch wait.
    always_comb begin
        streak_next = streak_reg;
        if (grant_i) begin
            streak_next = '0;
        end else if (grant_d) begin
            if (!if_req)
                streak_next = '0;
            else if (streak_reg < STREAK_MAX)
                streak_next = streak_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            streak_reg <= '0;
        else
            streak_reg <= streak_next;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch and load/store ports.
// One transaction in flight; response data is registered and held per port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    localparam int BW = DW / 8;

    arb_state_t    state_reg, state_next;
    owner_t        owner_reg;
    logic          busy, arb_en, grant_i, grant_d;
    logic          mem_we_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [DW-1:0] mem_wdata_reg;
    logic [BW-1:0] mem_be_reg;
    logic [DW-1:0] if_rdata_reg, d_rdata_reg;

    assign busy   = (state_reg == BUSY_I) || (state_reg == BUSY_D);
    // Grants stay low while reset is held even though they are combinational.
    assign arb_en = !busy && !reset;

    mem_arb_prio #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_prio (
        .clk     (clk),
        .reset   (reset),
        .if_req  (bus.if_req),
        .d_req   (bus.d_req),
        .arb_en  (arb_en),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, RESP: begin
                if (grant_d)
                    state_next = BUSY_D;
                else if (grant_i)
                    state_next = BUSY_I;
                else
                    state_next = IDLE;
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ack)
                    state_next = RESP;
            end
            default: state_next = IDLE;
        endcase
    end

    // Fetches are issued as full-word reads with no write data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_reg     <= OWN_I;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_be_reg    <= '0;
            if_rdata_reg  <= '0;
            d_rdata_reg   <= '0;
        end else begin
            if (grant_d) begin
                owner_reg     <= OWN_D;
                mem_we_reg    <= bus.d_we;
                mem_addr_reg  <= bus.d_addr;
                mem_wdata_reg <= bus.d_wdata;
                mem_be_reg    <= bus.d_be;
            end else if (grant_i) begin
                owner_reg     <= OWN_I;
                mem_we_reg    <= 1'b0;
                mem_addr_reg  <= bus.if_addr;
                mem_wdata_reg <= '0;
                mem_be_reg    <= '1;
            end
            if (busy && bus.mem_ack) begin
                if (owner_reg == OWN_D)
                    d_rdata_reg <= mem_we_reg ? '0 : bus.mem_rdata;
                else
                    if_rdata_reg <= bus.mem_rdata;
            end
        end
    end

    assign bus.if_gnt    = grant_i;
    assign bus.d_gnt     = grant_d;
    assign bus.if_rvalid = (state_reg == RESP) && (owner_reg == OWN_I);
    assign bus.d_rvalid  = (state_reg == RESP) && (owner_reg == OWN_D);
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.d_rdata   = d_rdata_reg;
    assign bus.mem_req   = busy;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.mem_be    = mem_be_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXS = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(
        .AW(AW), .DW(DW), .MAX_D_STREAK(MAXS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Transaction-level model: one outstanding access, last completed data per port.
    bit            m_busy, m_resp, m_resp_d, m_owner_d, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_if_rdata, m_d_rdata;
    logic [BW-1:0] m_be;
    int            m_streak, m_busy_cnt;
    int            lat = 1;
    bit            rand_mode, spur_en, force_ack;
    bit            eg_i, eg_d;
    logic [DW-1:0] memarr [logic [AW-1:0]];

    logic          s_if_gnt, s_d_gnt, s_mem_req, s_if_rvalid, s_d_rvalid, s_mem_we;
    logic [AW-1:0] s_mem_addr;
    logic [DW-1:0] s_mem_wdata, s_if_rdata, s_d_rdata;
    logic [BW-1:0] s_mem_be;
    byte           glog [$];
    int            gcyc [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BW; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_resp = 0; m_resp_d = 0; m_owner_d = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; m_be = '0; m_if_rdata = '0; m_d_rdata = '0;
        m_streak = 0; m_busy_cnt = 0;
    endtask

    task automatic step();
        logic [DW-1:0] old;
        if (m_busy && m_busy_cnt == lat - 1) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = (!m_we && memarr.exists(m_addr)) ? memarr[m_addr] : DW'($urandom);
        end else begin
            bus.mem_ack   = !m_busy && (force_ack || (spur_en && $urandom_range(0, 3) == 0));
            bus.mem_rdata = DW'($urandom);
        end
        @(negedge clk);
        eg_d = !m_busy && bus.d_req && (!bus.if_req || m_streak < MAXS);
        eg_i = !m_busy && bus.if_req && !eg_d;
        s_if_gnt = bus.if_gnt;     s_d_gnt = bus.d_gnt;       s_mem_req = bus.mem_req;
        s_if_rvalid = bus.if_rvalid; s_d_rvalid = bus.d_rvalid; s_mem_we = bus.mem_we;
        s_mem_addr = bus.mem_addr; s_mem_wdata = bus.mem_wdata; s_mem_be = bus.mem_be;
        s_if_rdata = bus.if_rdata; s_d_rdata = bus.d_rdata;
        if (s_d_gnt)  begin glog.push_back("D"); gcyc.push_back(cyc); end
        if (s_if_gnt) begin glog.push_back("I"); gcyc.push_back(cyc); end
        chk("if_gnt",    s_if_gnt,    eg_i);
        chk("d_gnt",     s_d_gnt,     eg_d);
        chk("mem_req",   s_mem_req,   m_busy);
        chk("mem_we",    s_mem_we,    m_we);
        chk("mem_addr",  s_mem_addr,  m_addr);
        chk("mem_wdata", s_mem_wdata, m_wdata);
        chk("mem_be",    s_mem_be,    m_be);
        chk("if_rvalid", s_if_rvalid, m_resp && !m_resp_d);
        chk("d_rvalid",  s_d_rvalid,  m_resp && m_resp_d);
        chk("if_rdata",  s_if_rdata,  m_if_rdata);
        chk("d_rdata",   s_d_rdata,   m_d_rdata);
        @(posedge clk);
        cyc++;
        if (m_busy && bus.mem_ack) begin
            m_busy = 0; m_resp = 1; m_resp_d = m_owner_d;
            if (!m_owner_d) begin
                m_if_rdata = bus.mem_rdata;
            end else if (m_we) begin
                m_d_rdata = '0;
                old = memarr.exists(m_addr) ? memarr[m_addr] : '0;
                memarr[m_addr] = merge(old, m_wdata, m_be);
            end else begin
                m_d_rdata = bus.mem_rdata;
            end
        end else begin
            m_resp = 0;
            if (m_busy) m_busy_cnt++;
        end
        if (eg_d) begin
            m_busy = 1; m_busy_cnt = 0; m_owner_d = 1;
            m_we = bus.d_we; m_addr = bus.d_addr; m_wdata = bus.d_wdata; m_be = bus.d_be;
            m_streak = bus.if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        end else if (eg_i) begin
            m_busy = 1; m_busy_cnt = 0; m_owner_d = 0;
            m_we = 0; m_addr = bus.if_addr; m_wdata = '0; m_be = '1;
            m_streak = 0;
        end
        if (rand_mode && (eg_d || eg_i)) lat = $urandom_range(1, 4);
        #1;
        if (eg_d) bus.d_req = 1'b0;
        if (eg_i) bus.if_req = 1'b0;
    endtask

    task automatic quiet();
        int n;
        n = 0;
        bus.if_req = 1'b0; bus.d_req = 1'b0; force_ack = 0;
        while ((m_busy || m_resp) && n < 20) begin
            step();
            n++;
        end
        if (m_busy || m_resp) begin
            n_total++;
            $display("FAIL quiet: still busy after %0d cycles, want idle", n);
        end
    endtask

    task automatic single_fetch(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        quiet();
        rand_mode = 0; lat = 2; memarr[addr] = data;
        bus.if_req = 1'b1; bus.if_addr = addr;
        step(); chk("fetch_gnt_c0", s_if_gnt, 1'b1);
        step(); chk("fetch_memreq_c1", s_mem_req, 1'b1); chk("fetch_addr_c1", s_mem_addr, addr);
        step(); chk("fetch_rvalid_c2", s_if_rvalid, 1'b0);
        step(); chk("fetch_rvalid_c3", s_if_rvalid, 1'b1); chk("fetch_rdata_c3", s_if_rdata, data);
    endtask

    task automatic store_load();
        quiet();
        lat = 1;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100;
        bus.d_wdata = 32'hDEADBEEF; bus.d_be = 4'hF;
        step(); chk("st_gnt", s_d_gnt, 1'b1);
        step();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100; bus.d_wdata = 32'h0;
        step(); chk("st_rvalid", s_d_rvalid, 1'b1); chk("st_rdata", s_d_rdata, 32'h0);
        chk("ld_gnt_in_resp", s_d_gnt, 1'b1);
        step();
        step(); chk("ld_rvalid", s_d_rvalid, 1'b1); chk("ld_rdata", s_d_rdata, 32'hDEADBEEF);
    endtask

    task automatic contention();
        int    base;
        string exp_order;
        quiet();
        lat = 1; exp_order = "DDDDIDDDDI"; base = glog.size();
        for (int i = 0; i < 20; i++) begin
            if (!bus.if_req) begin bus.if_req = 1'b1; bus.if_addr = AW'($urandom_range(0, 15)) << 2; end
            if (!bus.d_req) begin
                bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(0, 1));
                bus.d_addr = AW'($urandom_range(0, 15)) << 2; bus.d_wdata = DW'($urandom); bus.d_be = 4'hF;
            end
            step();
        end
        if (glog.size() < base + 10) begin
            n_total++;
            $display("FAIL contention_count: got %0d grants want 10", glog.size() - base);
        end else begin
            for (int k = 0; k < 10; k++) begin
                chk("contention_order", 32'(glog[base+k]), 32'(exp_order[k]));
                if (k > 0) chk("contention_gap", 32'(gcyc[base+k] - gcyc[base+k-1]), 32'd2);
            end
        end
    endtask

    task automatic byte_store();
        quiet();
        lat = 4;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200;
        bus.d_wdata = 32'h0000AB00; bus.d_be = 4'b0010;
        step(); chk("bs_gnt", s_d_gnt, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("bs_mem_be", s_mem_be, 4'b0010);
            chk("bs_mem_wdata", s_mem_wdata, 32'h0000AB00);
            chk("bs_mem_req", s_mem_req, 1'b1);
        end
        step(); chk("bs_rvalid", s_d_rvalid, 1'b1);
    endtask

    task automatic reset_mid();
        quiet();
        lat = 5;
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h104;
        step(); chk("rm_gnt_d", s_d_gnt, 1'b1);
        step(); chk("rm_busy", s_mem_req, 1'b1);
        #2; reset = 1'b1; #1;
        chk("rm_async_mem_req", bus.mem_req, 1'b0);
        chk("rm_async_d_rvalid", bus.d_rvalid, 1'b0);
        bus.if_req = 1'b0; bus.d_req = 1'b0; bus.mem_ack = 1'b0;
        model_reset();
        @(posedge clk); cyc++;
        #1; reset = 1'b0;
        step(); chk("rm_no_d_rvalid", s_d_rvalid, 1'b0); chk("rm_no_if_rvalid", s_if_rvalid, 1'b0);
    endtask

    task automatic spurious();
        quiet();
        force_ack = 1;
        step(); force_ack = 0;
        chk("sp_mem_req", s_mem_req, 1'b0);
        step(); chk("sp_if_rvalid", s_if_rvalid, 1'b0); chk("sp_d_rvalid", s_d_rvalid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.if_req = 1'b1; bus.if_addr = '0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        rand_mode = 0; spur_en = 0; force_ack = 0;
        model_reset();
        @(posedge clk); #1;
        chk("rst_if_gnt", bus.if_gnt, 1'b0);       chk("rst_d_gnt", bus.d_gnt, 1'b0);
        chk("rst_if_rvalid", bus.if_rvalid, 1'b0); chk("rst_d_rvalid", bus.d_rvalid, 1'b0);
        chk("rst_mem_req", bus.mem_req, 1'b0);     chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);  chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_mem_be", bus.mem_be, 4'h0);       chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        bus.if_req = 1'b0; bus.d_req = 1'b0; bus.mem_ack = 1'b0;
        @(posedge clk); #1; reset = 1'b0;

        single_fetch(32'h10, 32'h00500093);
        store_load();
        contention();
        byte_store();
        reset_mid();
        contention();
        single_fetch(32'h40, 32'h12345678);
        spurious();

        quiet();
        rand_mode = 1; spur_en = 1; lat = $urandom_range(1, 4);
        for (int i = 0; i < 1500; i++) begin
            if (!bus.if_req && $urandom_range(0, 2) == 0) begin
                bus.if_req = 1'b1; bus.if_addr = AW'($urandom_range(0, 15)) << 2;
            end
            if (!bus.d_req && $urandom_range(0, 2) == 0) begin
                bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(0, 1));
                bus.d_addr = AW'($urandom_range(0, 15)) << 2;
                bus.d_wdata = DW'($urandom); bus.d_be = BW'($urandom_range(0, 15));
            end
            step();
        end
        spur_en = 0;
        quiet();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one unified single-port memory between the CPU's instruction-fetch port and its load/store port. Accepts one request at a time from either requester, forwards it to the memory port with a req/ack handshake, and returns read data to the winning requester. Data accesses have priority; a streak counter guarantees fetch forward progress. Sits between the CPU core and the unified memory, replacing separate instruction and data memories.

## Interface
- AW, 32, address width
- DW, 32, data width; byte-enable width is DW/8
- MAX_D_STREAK, 4, consecutive data grants allowed while fetch is pending before fetch wins one grant; range 1..15

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  DW  fetched word
- d_req  in  1  data request; held with d_* fields stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_be  in  DW/8  byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle completion pulse for loads and stores
- d_rdata  out  DW  load data; 0 for stores
- mem_req  out  1  memory request, held until mem_ack
- mem_we, mem_addr, mem_wdata, mem_be  out  1/AW/DW/DW/8  registered copy of the granted request
- mem_ack  in  1  memory completed request this cycle
- mem_rdata  in  DW  read data, valid with mem_ack

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP. Owner register records I or D.
- IDLE: if d_req and (not if_req or streak < MAX_D_STREAK) → grant D; else if if_req → grant I. gnt is combinational in this cycle; request fields latch into mem_* registers; next state BUSY_I/BUSY_D.
- Streak: increments on D grant while if_req is high, saturating at MAX_D_STREAK; clears on any I grant and on a D grant with if_req low.
- BUSY_x: mem_req = 1 and mem_* stable until mem_ack. On mem_ack, latch mem_rdata (0 if owner = D and mem_we = 1) and go to RESP.
- RESP: drive owner's rvalid = 1 with latched data for exactly one cycle. Arbitration runs in the same cycle as IDLE: a new grant is possible and the next state is BUSY_x. Otherwise the next state is IDLE.
- Only one outstanding transaction exists. Never grant both in one cycle.
- mem_ack outside BUSY_x is ignored. Addresses pass through unchecked; no alignment check.
- Reset (any time, including mid-transaction): state IDLE, streak 0, and all outputs 0. The in-flight access is abandoned without rvalid, and the memory must tolerate mem_req dropping.

## Timing
- Reset values: if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we = 0; all data/address/be outputs = 0.
- Grant at cycle 0. mem_req high from cycle 1. mem_ack at cycle k (k ≥ 1). rvalid at cycle k+1. The next grant is possible at cycle k+1.
- Zero-wait memory (ack in the first mem_req cycle) gives one access per 2 cycles.
- rdata holds its value after rvalid until the next completion for that port.
- gnt depends combinationally on req. There is no combinational path from mem_ack to any output; rvalid/rdata are registered.

## Structure
- Package mem_arb_pkg holds the state enum (IDLE, BUSY_I, BUSY_D, RESP), the owner enum (OWN_I, OWN_D), and the default width constants.
- Sub-module mem_arb_prio contains the streak counter and the winner-select logic. Inputs: if_req, d_req, arb_en (IDLE/RESP). Outputs: grant_i, grant_d.
- The top level holds the FSM, the request registers and the response registers.

## Test plan
- Single fetch: if_req with if_addr=0x10, memory returns 0x00500093 with 2-cycle ack → if_gnt at cycle 0, if_rvalid at cycle 3 with if_rdata=0x00500093.
- Store then load: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=0xF, then load 0x100 → d_rvalid with d_rdata=0 after the store; d_rdata=0xDEADBEEF after the load.
- Contention with MAX_D_STREAK=4: if_req and d_req held high continuously, zero-wait memory → grant order D,D,D,D,I,D,D,D,D,I, one grant every 2 cycles.
- Byte store: d_be=4'b0010, d_wdata=0x0000AB00 → mem_be=0010 and mem_wdata=0x0000AB00 held stable for 3 stall cycles until mem_ack.
- Reset mid-access: assert reset during BUSY_D before mem_ack → mem_req=0 immediately (async), no d_rvalid, streak=0. A fetch issued after reset completes normally.
- Spurious ack: mem_ack pulsed in IDLE → no rvalid, state unchanged.
